phold_sched_support: RTL and testbench
======================================

PHOLD_SCHED_SUPPORT -- requirements
Module: phold_sched_support

Interface
REQ-001 The module SHALL have parameter NUM_CORE, default 16: number of cores, arbiter width.
REQ-002 The module SHALL have parameter NB_COREID, default 4: core index width, log2(NUM_CORE).
REQ-003 The module SHALL have parameter NB_LPID, default 5: LP id width.
REQ-004 The module SHALL have parameter TIME_WID, default 16: timestamp width.
REQ-005 The module SHALL have parameter MSG_WID, default 32: event message width, at least NB_LPID+TIME_WID+1.
REQ-006 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 The module SHALL have ports seed (input, 16) and rnd_next (input, 1): PRNG seed and advance strobe.
REQ-009 The module SHALL have port rnd, output, 8 bits: random byte.
REQ-010 The module SHALL have ports arb_req (input, NUM_CORE) and arb_stall (input, 1): arbiter requests and grant hold.
REQ-011 The module SHALL have ports arb_vgnt (output, NUM_CORE), arb_eval (output, 1) and arb_egnt (output, NB_COREID): one-hot grant, grant valid, encoded grant.
REQ-012 The module SHALL have ports msg (input, MSG_WID), sent_msg_vld (input, 1) and core_id (input, NB_COREID): dispatched event and its target core.
REQ-013 The module SHALL have port core_active, input, NUM_CORE bits: per-core busy flags.
REQ-014 The module SHALL have port stall, output, NUM_CORE bits: per-core LP-conflict stall.
REQ-015 The module SHALL have ports min_time (output, TIME_WID) and min_time_vld (output, 1): minimum active timestamp and its validity.

Function
REQ-016 PRNG: 16-bit Fibonacci LFSR state S; rnd SHALL equal S[7:0] at all times.
REQ-017 PRNG: on the first clk edge after rst_n rises, S SHALL load seed; a seed of 0 SHALL be replaced by 16'h0001.
REQ-018 PRNG: on every later edge with rnd_next=1, S SHALL become {S[14:0], S[15]^S[13]^S[12]^S[10]}; with rnd_next=0, S SHALL hold.
REQ-019 Arbiter: grants SHALL be registered, with one cycle latency from arb_req to arb_vgnt.
REQ-020 Arbiter: with arb_stall=0, each edge SHALL grant the first requester scanning upward from last-granted index+1, wrapping modulo NUM_CORE.
REQ-021 Arbiter: after reset the last-granted pointer SHALL be NUM_CORE-1, so index 0 has top priority.
REQ-022 Arbiter: arb_vgnt SHALL be one-hot or zero; arb_eval SHALL equal |arb_vgnt; arb_egnt SHALL encode the granted index.
REQ-023 Arbiter: with no request and arb_stall=0, arb_vgnt SHALL be 0 and arb_eval 0; arb_egnt and the pointer SHALL hold.
REQ-024 Arbiter: with arb_stall=1, arb_vgnt, arb_eval, arb_egnt and the pointer SHALL all hold, whatever arb_req is.
REQ-025 Monitor message fields: time = msg[TIME_WID-1:0]; LP id = msg[TIME_WID +: NB_LPID].
REQ-026 Monitor: on an edge with sent_msg_vld=1, entry core_id SHALL record the LP id and time; a write to an existing entry SHALL overwrite it.
REQ-027 Monitor: stall, min_time and min_time_vld SHALL be combinational from the entries and core_active, so the response lags the dispatch by one cycle.
REQ-028 Monitor: stall[i] SHALL be 1 iff core_active[i]=1 and some active j≠i has the same LP id and either time_j<time_i, or time_j==time_i with j<i.
REQ-029 Monitor: min_time SHALL be the minimum time over active entries, and min_time_vld SHALL be |core_active.
REQ-030 Monitor: with no core active, min_time SHALL be all ones.

Reset
REQ-031 rst_n low SHALL immediately force S=0 (rnd=0), arb_vgnt=0, arb_eval=0, arb_egnt=0 and pointer=NUM_CORE-1.
REQ-032 rst_n low SHALL immediately clear all monitor entries to LP id 0 and time 0.
REQ-033 Reset asserted mid-operation SHALL discard all state; after release, behaviour SHALL be identical to power-up.

Verification
REQ-034 seed=16'hFFFF, release reset, one idle edge, then 1 edge with rnd_next=1 -> S=16'hFFFE, rnd=8'hFE; with rnd_next=0 held -> rnd stays 8'hFE.
REQ-035 seed=0 -> after load S=16'h0001, rnd=8'h01.
REQ-036 arb_req=16'h0011 held, stall=0 -> arb_egnt sequence 0,4,0,4; arb_eval=1 from the first edge after assertion.
REQ-037 Stall held with arb_req changing -> grant held; arb_req=0 -> next edge arb_vgnt=0, arb_eval=0.
REQ-038 Dispatch core 2 LP 7 t=100, then core 5 LP 7 t=90, core_active=16'h0024 -> stall=16'h0004, min_time=90, min_time_vld=1.
REQ-039 Same dispatches but core 5 gets LP 7 t=100 -> stall=16'h0020; core_active=0 -> min_time=16'hFFFF, min_time_vld=0, stall=0.

Source files
------------

// File: rtl/phold_sched_support_if.sv
// Arbiter request/grant bus shared between the cores and the scheduler support block.
// The master side raises requests and stalls; the slave side returns registered grants.
interface phold_sched_support_if #(
    parameter int NUM_CORE  = 16,
    parameter int NB_COREID = 4
);
    logic [NUM_CORE-1:0]  arb_req;
    logic                 arb_stall;
    logic [NUM_CORE-1:0]  arb_vgnt;
    logic                 arb_eval;
    logic [NB_COREID-1:0] arb_egnt;

    modport master (
        output arb_req,
        output arb_stall,
        input  arb_vgnt,
        input  arb_eval,
        input  arb_egnt
    );

    modport slave (
        input  arb_req,
        input  arb_stall,
        output arb_vgnt,
        output arb_eval,
        output arb_egnt
    );
endinterface

// File: rtl/phold_sched_support.sv
// PHOLD scheduler support: seeded 16-bit LFSR, round-robin core arbiter, and an
// LP-conflict monitor that stalls later events for the same LP and tracks the minimum active time.
module phold_sched_support #(
    parameter int NUM_CORE  = 16,
    parameter int NB_COREID = 4,
    parameter int NB_LPID   = 5,
    parameter int TIME_WID  = 16,
    parameter int MSG_WID   = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [15:0]          seed,
    input  logic                 rnd_next,
    output logic [7:0]           rnd,
    phold_sched_support_if.slave arb,
    input  logic [MSG_WID-1:0]   msg,
    input  logic                 sent_msg_vld,
    input  logic [NB_COREID-1:0] core_id,
    input  logic [NUM_CORE-1:0]  core_active,
    output logic [NUM_CORE-1:0]  stall,
    output logic [TIME_WID-1:0]  min_time,
    output logic                 min_time_vld
);

    logic [15:0]          lfsr_p1;
    logic                 seeded;
    logic [NUM_CORE-1:0]  vgnt_p1;
    logic                 eval_p1;
    logic [NB_COREID-1:0] egnt_p1;
    logic [NB_COREID-1:0] ptr;
    logic                 found;
    logic [NB_COREID-1:0] pick;
    logic [NB_LPID-1:0]   ent_lp [NUM_CORE];
    logic [TIME_WID-1:0]  ent_tm [NUM_CORE];

    if (MSG_WID > NB_LPID + TIME_WID) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^msg[MSG_WID-1:NB_LPID+TIME_WID];
    end

    // PRNG: the first edge out of reset loads the seed; zero would lock the LFSR up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_p1 <= '0;
            seeded  <= 1'b0;
        end else if (!seeded) begin
            lfsr_p1 <= (seed == 16'h0000) ? 16'h0001 : seed;
            seeded  <= 1'b1;
        end else if (rnd_next) begin
            lfsr_p1 <= {lfsr_p1[14:0], lfsr_p1[15] ^ lfsr_p1[13] ^ lfsr_p1[12] ^ lfsr_p1[10]};
        end
    end

    assign rnd = lfsr_p1[7:0];

    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_CORE; k++) begin
            automatic int idx = (int'(ptr) + k) % NUM_CORE;
            if (!found && arb.arb_req[idx]) begin
                found = 1'b1;
                pick  = NB_COREID'(idx);
            end
        end
    end

    // Arbiter: stall freezes grant and pointer; an empty scan drops the grant but keeps egnt/pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vgnt_p1 <= '0;
            eval_p1 <= 1'b0;
            egnt_p1 <= '0;
            ptr     <= NB_COREID'(NUM_CORE - 1);
        end else if (!arb.arb_stall) begin
            if (found) begin
                vgnt_p1 <= NUM_CORE'(1) << pick;
                eval_p1 <= 1'b1;
                egnt_p1 <= pick;
                ptr     <= pick;
            end else begin
                vgnt_p1 <= '0;
                eval_p1 <= 1'b0;
            end
        end
    end

    assign arb.arb_vgnt = vgnt_p1;
    assign arb.arb_eval = eval_p1;
    assign arb.arb_egnt = egnt_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CORE; i++) begin
                ent_lp[i] <= '0;
                ent_tm[i] <= '0;
            end
        end else if (sent_msg_vld) begin
            ent_lp[core_id] <= msg[TIME_WID +: NB_LPID];
            ent_tm[core_id] <= msg[TIME_WID-1:0];
        end
    end

    // Conflict rule: an active core yields to any active core on the same LP with an
    // earlier time, ties broken toward the lower core index
    always_comb begin
        stall    = '0;
        min_time = '1;
        for (int i = 0; i < NUM_CORE; i++) begin
            if (core_active[i]) begin
                if (ent_tm[i] < min_time) begin
                    min_time = ent_tm[i];
                end
                for (int j = 0; j < NUM_CORE; j++) begin
                    if (j != i && core_active[j] && ent_lp[j] == ent_lp[i] &&
                        (ent_tm[j] < ent_tm[i] || (ent_tm[j] == ent_tm[i] && j < i))) begin
                        stall[i] = 1'b1;
                    end
                end
            end
        end
    end

    assign min_time_vld = |core_active;

endmodule

// File: tb/tb_phold_sched_support.sv
// Bench for phold_sched_support: table of monitor vectors, directed PRNG/arbiter/reset
// sequences, and a randomized run against an event-level reference model.
module tb_phold_sched_support;
    localparam int N  = 16;
    localparam int CW = 4;
    localparam int LW = 5;
    localparam int TW = 16;
    localparam int MW = 32;

    logic          clk;
    logic          rst_n;
    logic [15:0]   seed;
    logic          rnd_next;
    logic [7:0]    rnd;
    logic [MW-1:0] msg;
    logic          sent_msg_vld;
    logic [CW-1:0] core_id;
    logic [N-1:0]  core_active;
    logic [N-1:0]  stall;
    logic [TW-1:0] min_time;
    logic          min_time_vld;

    phold_sched_support_if #(.NUM_CORE(N), .NB_COREID(CW)) arb_bus ();

    phold_sched_support #(
        .NUM_CORE(N), .NB_COREID(CW), .NB_LPID(LW), .TIME_WID(TW), .MSG_WID(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .seed(seed), .rnd_next(rnd_next), .rnd(rnd),
        .arb(arb_bus), .msg(msg), .sent_msg_vld(sent_msg_vld), .core_id(core_id),
        .core_active(core_active), .stall(stall), .min_time(min_time),
        .min_time_vld(min_time_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [15:0] m_s;
    bit          m_loaded;
    int          m_ptr;
    int          m_egnt;
    logic [N-1:0] m_vgnt;
    int          m_lp [N];
    int          m_tm [N];

    typedef struct {
        int          core;
        int          lp;
        int          t;
        bit          vld;
        logic [15:0] act;
        logic [15:0] exp_stall;
        logic [15:0] exp_min;
        bit          exp_minv;
    } mvec_t;

    mvec_t tbl [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [N-1:0] model_stall(input logic [N-1:0] act);
        logic [N-1:0] r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (act[i] && act[j] && i != j && m_lp[i] == m_lp[j] &&
                    (m_tm[j] < m_tm[i] || (m_tm[j] == m_tm[i] && j < i)))
                    r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [15:0] model_min(input logic [N-1:0] act);
        int m = 65535;
        for (int i = 0; i < N; i++)
            if (act[i] && m_tm[i] < m) m = m_tm[i];
        return 16'(m);
    endfunction

    task automatic model_reset();
        m_s = 16'h0000; m_loaded = 0; m_ptr = N - 1; m_egnt = 0; m_vgnt = '0;
        for (int i = 0; i < N; i++) begin m_lp[i] = 0; m_tm[i] = 0; end
    endtask

    // Advance the model by one edge using the inputs currently applied
    task automatic model_edge();
        int win = -1;
        if (!m_loaded) begin
            m_s = (seed == 16'h0) ? 16'h0001 : seed;
            m_loaded = 1;
        end else if (rnd_next) begin
            m_s = 16'((int'(m_s) * 2) % 65536) |
                  16'(m_s[15] ^ m_s[13] ^ m_s[12] ^ m_s[10]);
        end
        if (!arb_bus.arb_stall) begin
            for (int k = 1; k <= N; k++)
                if (win < 0 && arb_bus.arb_req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            if (win >= 0) begin
                m_vgnt = '0; m_vgnt[win] = 1'b1; m_egnt = win; m_ptr = win;
            end else begin
                m_vgnt = '0;
            end
        end
        if (sent_msg_vld) begin
            m_lp[core_id] = int'(msg[TW +: LW]);
            m_tm[core_id] = int'(msg[TW-1:0]);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rnd"},  32'(rnd), 32'(m_s[7:0]));
        chk({tag, ".vgnt"}, 32'(arb_bus.arb_vgnt), 32'(m_vgnt));
        chk({tag, ".eval"}, 32'(arb_bus.arb_eval), 32'(m_vgnt != 0));
        chk({tag, ".egnt"}, 32'(arb_bus.arb_egnt), 32'(m_egnt));
        chk({tag, ".stall"}, 32'(stall), 32'(model_stall(core_active)));
        chk({tag, ".min"},  32'(min_time), 32'(model_min(core_active)));
        chk({tag, ".minv"}, 32'(min_time_vld), 32'(core_active != 0));
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic idle_inputs();
        rnd_next = 0; arb_bus.arb_req = '0; arb_bus.arb_stall = 0;
        msg = '0; sent_msg_vld = 0; core_id = '0; core_active = '0;
    endtask

    initial begin
        tbl[0] = '{2, 7, 100, 1'b1, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
        tbl[1] = '{5, 7,  90, 1'b1, 16'h0024, 16'h0004, 16'd90,  1'b1};
        tbl[2] = '{5, 7, 100, 1'b1, 16'h0024, 16'h0020, 16'd100, 1'b1};
        tbl[3] = '{0, 0,   0, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0};
        tbl[4] = '{3, 1,  50, 1'b1, 16'h000C, 16'h0000, 16'd50,  1'b1};
        tbl[5] = '{0, 0,   0, 1'b0, 16'h0001, 16'h0000, 16'd0,   1'b1};
        tbl[6] = '{0, 7,   5, 1'b1, 16'h0025, 16'h0024, 16'd5,   1'b1};

        idle_inputs();
        seed = 16'hFFFF;
        rst_n = 1'b1;
        #2;
        apply_reset();
        chk("rst.rnd0", 32'(rnd), 32'h0);

        // PRNG: load, one advance, hold
        tick();
        check_all("prng_load");
        chk("prng_load.rnd", 32'(rnd), 32'hFF);
        rnd_next = 1;
        tick();
        chk("prng_step.rnd", 32'(rnd), 32'hFE);
        rnd_next = 0;
        tick(); tick();
        chk("prng_hold.rnd", 32'(rnd), 32'hFE);
        check_all("prng_hold");

        seed = 16'h0000;
        apply_reset();
        tick();
        chk("prng_zero.rnd", 32'(rnd), 32'h01);
        check_all("prng_zero");

        // Arbiter round robin between cores 0 and 4
        arb_bus.arb_req = 16'h0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("rr%0d.egnt", k), 32'(arb_bus.arb_egnt), (k % 2 == 0) ? 32'd0 : 32'd4);
            chk($sformatf("rr%0d.eval", k), 32'(arb_bus.arb_eval), 32'd1);
            check_all("rr");
        end
        arb_bus.arb_stall = 1;
        arb_bus.arb_req = 16'h0100;
        tick();
        arb_bus.arb_req = 16'h8002;
        tick();
        chk("stall.vgnt", 32'(arb_bus.arb_vgnt), 32'h0010);
        chk("stall.egnt", 32'(arb_bus.arb_egnt), 32'd4);
        check_all("stall");
        arb_bus.arb_stall = 0;
        arb_bus.arb_req = '0;
        tick();
        chk("noreq.vgnt", 32'(arb_bus.arb_vgnt), 32'h0);
        chk("noreq.eval", 32'(arb_bus.arb_eval), 32'h0);
        chk("noreq.egnt", 32'(arb_bus.arb_egnt), 32'd4);
        arb_bus.arb_req = 16'h0020;
        tick();
        chk("wrap.egnt", 32'(arb_bus.arb_egnt), 32'd5);

        // Monitor vector table
        idle_inputs();
        apply_reset();
        foreach (tbl[v]) begin
            core_id = CW'(tbl[v].core);
            msg = '0;
            msg[TW +: LW] = LW'(tbl[v].lp);
            msg[TW-1:0] = TW'(tbl[v].t);
            sent_msg_vld = tbl[v].vld;
            core_active = tbl[v].act;
            tick();
            sent_msg_vld = 0;
            chk($sformatf("mon%0d.stall", v), 32'(stall), 32'(tbl[v].exp_stall));
            chk($sformatf("mon%0d.min", v), 32'(min_time), 32'(tbl[v].exp_min));
            chk($sformatf("mon%0d.minv", v), 32'(min_time_vld), 32'(tbl[v].exp_minv));
            check_all("mon");
        end

        // Randomized run with a mid-run reset
        for (int c = 0; c < 400; c++) begin
            seed = 16'($urandom);
            rnd_next = 1'($urandom);
            arb_bus.arb_req = 16'($urandom & $urandom & $urandom);
            arb_bus.arb_stall = ($urandom_range(0, 3) == 0);
            msg = 32'($urandom);
            msg[TW +: LW] = LW'($urandom_range(0, 3));
            sent_msg_vld = 1'($urandom);
            core_id = CW'($urandom);
            core_active = 16'($urandom);
            if (c == 200) apply_reset();
            tick();
            check_all($sformatf("rand%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
